// File: rtl/rr_mux2_arbiter.sv
// Two-input round-robin burst arbiter feeding one registered output beat.
// A requester keeps the grant until it delivers a beat with last set; ties
// in IDLE are broken by a one-bit pointer that favours whoever lost most
// recently.
module rr_mux2_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,

    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,

    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             out_sel,

    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_sel_q, out_sel_d;

    logic             load_en;
    logic             xfer0;
    logic             xfer1;

    assign load_en = !out_valid_q || out_ready;
    assign xfer0   = in0_valid && in0_ready;
    assign xfer1   = in1_valid && in1_ready;

    // Grant decode: readies depend only on state, pointer and handshake signals.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (rst_n && load_en) begin
            unique case (state_q)
                StIdle: begin
                    if (in0_valid && (!in1_valid || !ptr_q)) begin
                        in0_ready = 1'b1;
                    end else if (in1_valid) begin
                        in1_ready = 1'b1;
                    end
                end
                StLock0: in0_ready = 1'b1;
                StLock1: in1_ready = 1'b1;
                default: ;
            endcase
        end
    end

    // Next state, pointer and output register contents.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (xfer0) begin
            out_valid_d = 1'b1;
            out_data_d  = in0_data;
            out_last_d  = in0_last;
            out_sel_d   = 1'b0;
            if (in0_last) begin
                state_d = StIdle;
                ptr_d   = 1'b1;
            end else begin
                state_d = StLock0;
            end
        end else if (xfer1) begin
            out_valid_d = 1'b1;
            out_data_d  = in1_data;
            out_last_d  = in1_last;
            out_sel_d   = 1'b1;
            if (in1_last) begin
                state_d = StIdle;
                ptr_d   = 1'b0;
            end else begin
                state_d = StLock1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    // Forced low during reset so a stale lock never shows before the reset edge.
    assign busy      = rst_n && (state_q != StIdle);

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Directed bench for rr_mux2_arbiter: arbitration order, burst locking,
// backpressure and reset behaviour.
module tb_rr_mux2_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in0_valid, in0_last, in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid, in1_last, in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             out_valid, out_last, out_ready, out_sel, busy;
    logic [WIDTH-1:0] out_data;

    int vectors = 0;
    int errors  = 0;

    rr_mux2_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with everything asserted on the inputs
        rst_n = 1'b0; out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h00; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h00; in1_last = 1'b1;
        #1;
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_busy", busy, 0);
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_in0_ready2", in0_ready, 0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Alternating single beats: 0,1,0,1
        in0_valid = 1'b1; in0_data = 8'h10; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h20; in1_last = 1'b1;
        #1;
        chk("rr_in0_ready", in0_ready, 1);
        chk("rr_in1_ready", in1_ready, 0);
        tick();
        chk("rr1_sel", out_sel, 0); chk("rr1_data", out_data, 8'h10); chk("rr1_valid", out_valid, 1);
        chk("rr1_in1_ready", in1_ready, 1); chk("rr1_in0_ready", in0_ready, 0);
        in0_data = 8'h11;
        tick();
        chk("rr2_sel", out_sel, 1); chk("rr2_data", out_data, 8'h20);
        in1_data = 8'h21;
        tick();
        chk("rr3_sel", out_sel, 0); chk("rr3_data", out_data, 8'h11);
        tick();
        chk("rr4_sel", out_sel, 1); chk("rr4_data", out_data, 8'h21);
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_data_hold", out_data, 8'h21);

        // in1 3-beat burst, in0 arrives mid-burst and must wait
        in1_valid = 1'b1; in1_data = 8'hA1; in1_last = 1'b0;
        #1;
        chk("b1_in1_ready", in1_ready, 1);
        tick();
        chk("b1_data", out_data, 8'hA1); chk("b1_busy", busy, 1); chk("b1_sel", out_sel, 1);
        in1_data = 8'hA2;
        in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b1;
        #1;
        chk("b2_in0_ready", in0_ready, 0); chk("b2_in1_ready", in1_ready, 1);
        tick();
        chk("b2_data", out_data, 8'hA2);
        in1_data = 8'hA3; in1_last = 1'b1;
        #1;
        chk("b3_in0_ready", in0_ready, 0);
        tick();
        chk("b3_data", out_data, 8'hA3); chk("b3_last", out_last, 1); chk("b3_busy", busy, 0);
        in1_valid = 1'b0;
        #1;
        chk("b4_in0_ready", in0_ready, 1);
        tick();
        chk("b4_data", out_data, 8'h55); chk("b4_sel", out_sel, 0);
        in0_valid = 1'b0;

        // Backpressure: held beat stable, then one-cycle accept reloads with no bubble
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h66; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h77; in1_last = 1'b1;
        #1;
        chk("bp_in0_ready", in0_ready, 0); chk("bp_in1_ready", in1_ready, 0);
        tick();
        chk("bp_data_hold", out_data, 8'h55); chk("bp_valid_hold", out_valid, 1);
        chk("bp_in1_ready2", in1_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_in1_grant", in1_ready, 1); chk("bp_in0_grant", in0_ready, 0);
        tick();
        out_ready = 1'b0;
        chk("bp_new_data", out_data, 8'h77); chk("bp_new_sel", out_sel, 1);
        chk("bp_new_valid", out_valid, 1);
        tick();
        chk("bp_one_only", out_data, 8'h77);
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_drain", out_valid, 0);

        // in0 burst stalls for 4 cycles while in1 waits
        in0_valid = 1'b1; in0_data = 8'hB1; in0_last = 1'b0;
        tick();
        chk("st_b1_data", out_data, 8'hB1); chk("st_busy0", busy, 1);
        in0_valid = 1'b0;
        in1_valid = 1'b1; in1_data = 8'hC1; in1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("st_in1_ready", in1_ready, 0);
            chk("st_busy", busy, 1);
            tick();
        end
        chk("st_bubble", out_valid, 0);
        in0_valid = 1'b1; in0_data = 8'hB2; in0_last = 1'b1;
        #1;
        chk("st_in0_ready", in0_ready, 1); chk("st_in1_ready2", in1_ready, 0);
        tick();
        chk("st_b2_data", out_data, 8'hB2); chk("st_b2_last", out_last, 1); chk("st_idle", busy, 0);
        in0_valid = 1'b0;
        #1;
        chk("st_in1_grant", in1_ready, 1);
        tick();
        chk("st_c1_data", out_data, 8'hC1); chk("st_c1_sel", out_sel, 1);
        in1_valid = 1'b0;
        tick();

        // Reset while locked on in1 with a held beat
        in1_valid = 1'b1; in1_data = 8'hD1; in1_last = 1'b0;
        tick();
        chk("rl_busy", busy, 1); chk("rl_valid", out_valid, 1); chk("rl_sel", out_sel, 1);
        rst_n = 1'b0; in1_data = 8'hD2;
        #1;
        chk("rl_in1_ready", in1_ready, 0); chk("rl_busy_low", busy, 0);
        tick();
        chk("rl_out_valid", out_valid, 0); chk("rl_out_data", out_data, 0);
        rst_n = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hE0; in0_last = 1'b1;
        #1;
        chk("rl_busy_after", busy, 0);
        chk("rl_in0_grant", in0_ready, 1); chk("rl_in1_grant", in1_ready, 0);
        tick();
        chk("rl_e0_sel", out_sel, 0); chk("rl_e0_data", out_data, 8'hE0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Backstop against an unexpected stall of the stimulus sequence
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_mux2_arbiter.md
RR_MUX2_ARBITER -- requirements
Module: rr_mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of both input channels and the output channel.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 in0_valid  input  1  requester 0 presents a beat.
REQ-005 in0_data  input  WIDTH  requester 0 beat data.
REQ-006 in0_last  input  1  requester 0 beat is the final beat of its burst.
REQ-007 in0_ready  output  1  requester 0 beat accepted this cycle when high with in0_valid.
REQ-008 in1_valid, in1_data, in1_last, in1_ready: same directions, widths and meanings as in0_*, for requester 1.
REQ-009 out_valid  output  1  output register holds a beat.
REQ-010 out_data  output  WIDTH  registered muxed beat.
REQ-011 out_last  output  1  registered last flag of the held beat.
REQ-012 out_ready  input  1  downstream accepts the held beat when high with out_valid.
REQ-013 out_sel  output  1  source of the held beat (0 = requester 0, 1 = requester 1).
REQ-014 busy  output  1  high while a burst is locked (state not IDLE).

Function
REQ-015 States: IDLE, LOCK0, LOCK1; round-robin pointer ptr (1 bit) names the favoured requester in IDLE.
REQ-016 load_en = !out_valid || out_ready; no input is accepted when load_en is low.
REQ-017 IDLE, load_en high: grant goes to the single valid requester; if both valid, grant goes to requester ptr; granted inX_ready = 1, other ready = 0.
REQ-018 LOCK0: in0_ready = load_en, in1_ready = 0; LOCK1: the mirror.
REQ-019 inX_ready is combinational from state, ptr, in*_valid, out_valid and out_ready only; it does not depend on in*_data or in*_last.
REQ-020 Transfer of a beat from X (inX_valid && inX_ready): out_data <= inX_data, out_last <= inX_last, out_sel <= X, out_valid <= 1 next edge.
REQ-021 Transfer with inX_last = 0: next state LOCKX, ptr unchanged.
REQ-022 Transfer with inX_last = 1: next state IDLE, ptr <= ~X, for both IDLE and LOCKX.
REQ-023 In LOCKX, the state is held indefinitely while inX_valid is low; the other requester is never served mid-burst.
REQ-024 No transfer and out_ready high: out_valid <= 0; out_data, out_last and out_sel hold.
REQ-025 Simultaneous downstream accept and new transfer in the same cycle: out_valid stays 1 and the new beat replaces the old (zero bubble).
REQ-026 Latency: one cycle from input transfer to out_valid; sustained throughput one beat per cycle when out_ready is held high.
REQ-027 No valid requester in IDLE: both readies low, state and ptr unchanged.
REQ-028 busy = (state != IDLE), combinational from the state register.

Reset
REQ-029 rst_n low at an edge: state IDLE, ptr 0, out_valid 0, out_data 0, out_last 0, out_sel 0.
REQ-030 While rst_n is low: in0_ready = 0, in1_ready = 0, busy = 0.
REQ-031 Reset mid-burst or with a held beat: the burst and the held beat are discarded; no partial completion after reset.

Verification
REQ-032 After reset, in0 and in1 both valid with single beats (last = 1), out_ready = 1 -> out_sel sequence 0,1,0,1; one beat per cycle; out_data matches the source each cycle.
REQ-033 In IDLE with ptr = 0, in1 3-beat burst (0xA1, 0xA2, 0xA3, last on third) starts alone; in0 raises valid at beat 2 -> in0_ready = 0 until 0xA3 transfers; the next beat is from in0.
REQ-034 out_ready = 0 with out_valid = 1 -> both readies 0 and out_data stable; out_ready raised for one cycle -> exactly one new beat loads the same cycle, no bubble.
REQ-035 LOCK0 with in0_valid dropped for 4 cycles while in1_valid = 1 -> in1_ready stays 0, busy = 1; the burst resumes and completes, then in1 is granted.
REQ-036 rst_n pulled low in LOCK1 with out_valid = 1 -> next cycle out_valid = 0, busy = 0, ptr = 0; a simultaneous request from both requesters then grants in0.
